// File: rtl/anc_pkg.sv
// Shared definitions for the ANC frame scheduler: FSM state encoding and
// default filter geometry.
package anc_pkg;

    localparam int NTAPS_DEF   = 32;
    localparam int MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FIR   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_LMS   = 3'd5
    } anc_state_t;

endpackage

// File: rtl/anc_tap_cnt.sv
// Tap index counter: synchronous clear, enable, wrap at MAXV and a terminal
// flag that is high while the count sits on MAXV.
module anc_tap_cnt #(
    parameter int WIDTH = 5,
    parameter int MAXV  = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAXV);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == MAX_C);
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/anc_frame_sched.sv
// Per-frame scheduler for the ANC filter: sequences sample load, FIR MAC
// issue, accumulator drain, output strobe and optional LMS weight update.
module anc_frame_sched
    import anc_pkg::*;
#(
    parameter int NTAPS   = NTAPS_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int AW      = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_done,
    input  logic          bypass_mode_sel,
    input  logic          upd_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mac_stall,
    output logic [AW-1:0] tap_addr,
    output logic          smp_load,
    output logic          acc_clr,
    output logic          fir_en,
    output logic          lms_en,
    output logic          out_valid,
    output logic          busy,
    output logic [7:0]    late_cnt
);

    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

    anc_state_t state_q, state_d;
    logic       byp_q, byp_d;
    logic       upd_q, upd_d;
    logic [2:0] drain_q, drain_d;
    logic [7:0] late_q, late_d;
    logic       cnt_en, cnt_clr, tap_last;

    anc_tap_cnt #(
        .WIDTH (AW),
        .MAXV  (NTAPS - 1)
    ) u_tap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .cnt   (tap_addr),
        .last  (tap_last)
    );

    assign in_ready = (state_q == ST_IDLE) && init_done;
    assign busy     = (state_q != ST_IDLE);
    assign late_cnt = late_q;

    always_comb begin
        state_d   = state_q;
        byp_d     = byp_q;
        upd_d     = upd_q;
        drain_d   = drain_q;
        late_d    = late_q;
        smp_load  = 1'b0;
        acc_clr   = 1'b0;
        fir_en    = 1'b0;
        lms_en    = 1'b0;
        out_valid = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                smp_load = 1'b1;
                acc_clr  = 1'b1;
                cnt_clr  = 1'b1;
                drain_d  = '0;
                byp_d    = bypass_mode_sel;
                upd_d    = upd_en;
                state_d  = bypass_mode_sel ? ST_OUT : ST_FIR;
            end
            ST_FIR: begin
                if (!mac_stall) begin
                    fir_en = 1'b1;
                    cnt_en = 1'b1;
                    if (tap_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!mac_stall) begin
                    if (drain_q == DRAIN_LAST) begin
                        drain_d = '0;
                        state_d = ST_OUT;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (upd_q && !byp_q) begin
                    state_d = ST_LMS;
                end else begin
                    state_d = ST_IDLE;
                    // A sample set already waiting when we return counts as late.
                    if (in_valid && late_q != 8'hFF) late_d = late_q + 8'd1;
                end
            end
            ST_LMS: begin
                if (!mac_stall) begin
                    lms_en = 1'b1;
                    cnt_en = 1'b1;
                    if (tap_last) begin
                        state_d = ST_IDLE;
                        if (in_valid && late_q != 8'hFF) late_d = late_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            byp_q   <= 1'b0;
            upd_q   <= 1'b0;
            drain_q <= '0;
            late_q  <= '0;
        end else begin
            state_q <= state_d;
            byp_q   <= byp_d;
            upd_q   <= upd_d;
            drain_q <= drain_d;
            late_q  <= late_d;
        end
    end

endmodule

// File: doc/anc_frame_sched.md
ANC_FRAME_SCHED -- requirements
Module: anc_frame_sched

Interface
REQ-001 SHALL have parameter NTAPS, default 32: number of FIR/LMS taps, power of two, 4..256.
REQ-002 SHALL have parameter MAC_LAT, default 2: cycles from last tap issue to a valid accumulator, 1..7.
REQ-003 SHALL have parameter AW, default $clog2(NTAPS): width of the tap address.
REQ-004 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port init_done  input  1  configuration shift-in complete; no frames are accepted while it is low.
REQ-007 SHALL have port bypass_mode_sel  input  1  skip filtering; the sample goes straight to output.
REQ-008 SHALL have port upd_en  input  1  LMS weight update enable.
REQ-009 SHALL have port in_valid  input  1  merged sample-set valid from the input merge.
REQ-010 SHALL have port in_ready  output  1  scheduler can accept a sample set.
REQ-011 SHALL have port mac_stall  input  1  shared MAC/weight RAM not available this cycle.
REQ-012 SHALL have port tap_addr  output  AW  current tap index.
REQ-013 SHALL have port smp_load  output  1  one-cycle pulse: capture x/e/a/u into the delay line.
REQ-014 SHALL have port acc_clr  output  1  clear the FIR accumulator.
REQ-015 SHALL have port fir_en  output  1  FIR MAC issue for tap_addr.
REQ-016 SHALL have port lms_en  output  1  weight update issue for tap_addr.
REQ-017 SHALL have port out_valid  output  1  one-cycle pulse: output sample ready.
REQ-018 SHALL have port busy  output  1  state is not IDLE.
REQ-019 SHALL have port late_cnt  output  8  saturating count of frames that waited on the scheduler.

Function
REQ-020 SHALL implement the states IDLE, LOAD, FIR, DRAIN, OUT, LMS.
REQ-021 SHALL drive in_ready = (state==IDLE) && init_done, combinationally from registered state only.
REQ-022 SHALL treat a frame as accepted when in_valid && in_ready; the next state is then LOAD.
REQ-023 SHALL, in LOAD (exactly 1 cycle), assert smp_load and acc_clr and sample bypass_mode_sel and upd_en into frame-local registers.
REQ-024 SHALL go from LOAD to OUT when the latched bypass bit is 1, else to FIR with tap_addr=0.
REQ-025 SHALL, in FIR, assert fir_en with tap_addr stepping 0..NTAPS-1, one tap per non-stalled cycle, and go to DRAIN after tap NTAPS-1 issues.
REQ-026 SHALL hold DRAIN for exactly MAC_LAT cycles, counted only on non-stalled cycles, then go to OUT.
REQ-027 SHALL, in OUT (1 cycle), pulse out_valid, then go to LMS when the latched upd_en and !bypass, else to IDLE.
REQ-028 SHALL, in LMS, assert lms_en with tap_addr stepping 0..NTAPS-1, then go to IDLE.
REQ-029 SHALL, while mac_stall=1 in FIR, DRAIN or LMS, force fir_en/lms_en to 0 and freeze tap_addr, the drain counter and the state; LOAD and OUT ignore mac_stall.
REQ-030 SHALL wrap tap_addr to 0 on the FIR->DRAIN and LMS->IDLE transitions; it never exceeds NTAPS-1.
REQ-031 SHALL sample bypass_mode_sel/upd_en only in LOAD; changes mid-frame have no effect until the next frame.
REQ-032 SHALL, with MAC_LAT=2 and no stalls, give out_valid NTAPS+4 cycles after the accept edge, and in_ready high again at NTAPS+5 (no update) or 2*NTAPS+5 (update).
REQ-033 SHALL, with bypass, give out_valid 2 cycles after the accept edge.
REQ-034 SHALL increment late_cnt when in_valid=1 on the cycle the state enters IDLE from OUT/LMS, saturating at 255.
REQ-035 SHALL, when init_done falls mid-frame, complete the frame and then hold in IDLE with in_ready=0.
REQ-036 SHALL never assert fir_en and lms_en in the same cycle, nor assert more than one of smp_load/out_valid in a cycle.

Reset
REQ-037 SHALL, on rst_n low, asynchronously force state=IDLE, tap_addr=0, drain count=0, late_cnt=0, latched bits=0, and all strobes low.
REQ-038 SHALL abort any frame in progress on reset mid-operation with no out_valid, and restart cleanly in IDLE after release.

Structure
REQ-039 SHALL place the state enum and the NTAPS/MAC_LAT defaults in shared package anc_pkg.
REQ-040 SHALL use a single sub-module anc_tap_cnt (enable/clear/wrap counter with terminal flag) for the tap_addr sequencing in FIR and LMS.

Verification (NTAPS=4, MAC_LAT=2)
REQ-041 SHALL cover: accept at cycle 0, bypass=0, upd_en=0 -> smp_load@1, fir_en@2..5 with addr 0,1,2,3, out_valid@8, in_ready@9.
REQ-042 SHALL cover: same with upd_en=1 -> lms_en@9..12 with addr 0..3, in_ready@13.
REQ-043 SHALL cover: bypass=1 -> out_valid@2, no fir_en/lms_en, in_ready@3.
REQ-044 SHALL cover: mac_stall=1 in cycles 3..4 -> fir_en pattern 1,0,0,1,1,1 over cycles 2..7 with addr 0,1,1,1,2,3, out_valid@10.
REQ-045 SHALL cover: in_valid held through the frame -> late_cnt 0->1, and 300 such frames -> late_cnt=255.
REQ-046 SHALL cover: rst_n low at cycle 4 -> all outputs 0 immediately, no out_valid, accept possible one cycle after release with init_done=1.
